vga_scroll_sequencer: RTL and testbench

//  Frame-level controller for the VGA pattern datapath. It produces the horizontal scroll offset
//  (the pixel-x subtrahend) and the pattern select. It advances them once per frame, on the vsync

---
 rtl/vga_scroll_sequencer.sv | 145 ++++++++++++++
 tb/tb_vga_scroll_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scroll_sequencer.sv
// Frame-level scroll and pattern sequencer for the VGA pattern datapath.
// Advances a 10-bit scroll offset and a pattern index once per frame, on the
// clk-domain edge into the vsync pulse, with run/pause/single-step control
// from two asynchronous user buttons and optional pattern auto-cycling.
module vga_scroll_sequencer #(
  parameter logic VSYNC_ACT   = 1'b0,
  parameter int   HOLD_FRAMES = 120,
  parameter int   PAT_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             dir,
  input  logic [2:0]       speed,
  input  logic             pause_btn,
  input  logic             step_btn,
  input  logic             auto_cycle,
  output logic [9:0]       scroll_x,
  output logic [PAT_W-1:0] pattern_sel,
  output logic             frame_tick,
  output logic             paused
);

  localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    STEP  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             vs_q;
  logic             frame_start;
  logic             pause_s1, pause_s2, pause_q;
  logic             step_s1, step_s2, step_q;
  logic [1:0]       warm;
  logic             pause_edge, step_edge;
  logic             adv_en;
  logic [2:0]       adv_amt;
  logic [CNT_W-1:0] frame_cnt;

  // Wrapping 10-bit offset update; the amount is zero-extended.
  function automatic logic [9:0] next_scroll(input logic [9:0] cur,
                                             input logic [2:0] amt,
                                             input logic       down);
    logic [9:0] amt_ext;
    amt_ext = {7'd0, amt};
    return down ? (cur - amt_ext) : (cur + amt_ext);
  endfunction

  assign frame_start = (vsync == VSYNC_ACT) && (vs_q != VSYNC_ACT);

  // The history flops stay at 1 until the synchronisers have filled with real
  // pin samples (warm[1]), so a button held through reset never reads as a
  // fresh press; after warm-up they simply track the synchronised level.
  assign pause_edge = warm[1] & pause_s2 & ~pause_q;
  assign step_edge  = warm[1] & step_s2  & ~step_q;

  // vsync history, button synchronisers and edge-history flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q     <= VSYNC_ACT;
      pause_s1 <= 1'b0;
      pause_s2 <= 1'b0;
      pause_q  <= 1'b1;
      step_s1  <= 1'b0;
      step_s2  <= 1'b0;
      step_q   <= 1'b1;
      warm     <= 2'b00;
    end else begin
      vs_q     <= vsync;
      pause_s1 <= pause_btn;
      pause_s2 <= pause_s1;
      step_s1  <= step_btn;
      step_s2  <= step_s1;
      warm     <= {warm[0], 1'b1};
      if (warm[1]) begin
        pause_q <= pause_s2;
        step_q  <= step_s2;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // FSM next state: pause edges always win over step edges and frame ends.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (pause_edge) state_next = PAUSE;
      PAUSE:   if (pause_edge) state_next = RUN;
               else if (step_edge) state_next = STEP;
      STEP:    if (pause_edge) state_next = RUN;
               else if (frame_start) state_next = PAUSE;
      default: state_next = RUN;
    endcase
  end

  // FSM outputs: whether this frame advances, and by how much. A pause edge
  // landing on the stepping frame cancels the step rather than taking it.
  always_comb begin
    adv_en  = 1'b0;
    adv_amt = speed;
    unique case (state)
      RUN:     adv_en = frame_start;
      STEP: begin
        adv_en  = frame_start && !pause_edge;
        adv_amt = (speed == 3'd0) ? 3'd1 : speed;
      end
      default: adv_en = 1'b0;
    endcase
  end

  // Scroll offset, pattern scheduler, frame tick and paused flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scroll_x    <= 10'd0;
      pattern_sel <= '0;
      frame_cnt   <= '0;
      frame_tick  <= 1'b0;
      paused      <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      paused     <= (state_next != RUN);
      if (adv_en) scroll_x <= next_scroll(scroll_x, adv_amt, dir);
      if (!auto_cycle) begin
        frame_cnt <= '0;
      end else if (adv_en) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt   <= '0;
          pattern_sel <= pattern_sel + 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_scroll_sequencer.sv
// Scoreboard bench for vga_scroll_sequencer: each frame pushes the expected
// scroll/pattern/tick cycle, and the monitor pops one entry per frame_tick.
module tb_vga_scroll_sequencer;

  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic       dir = 1'b0;
  logic [2:0] speed = 3'd0;
  logic       pause_btn = 1'b0;
  logic       step_btn = 1'b0;
  logic       auto_cycle = 1'b0;
  logic [9:0] scroll_x;
  logic [1:0] pattern_sel;
  logic       frame_tick;
  logic       paused;

  vga_scroll_sequencer #(
    .VSYNC_ACT  (1'b0),
    .HOLD_FRAMES(HOLD),
    .PAT_W      (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .dir        (dir),
    .speed      (speed),
    .pause_btn  (pause_btn),
    .step_btn   (step_btn),
    .auto_cycle (auto_cycle),
    .scroll_x   (scroll_x),
    .pattern_sel(pattern_sel),
    .frame_tick (frame_tick),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] scroll;
    logic [1:0] pat;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // Model state.
  typedef enum int {M_RUN, M_PAUSE, M_STEP} mstate_t;
  mstate_t    m_state;
  logic [9:0] m_scroll;
  logic [1:0] m_pat;
  int         m_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_tick) begin
      if (sb.size() == 0) begin
        check_val("tick_unexpected", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("scroll_x", scroll_x, e.scroll);
        check_val("pattern_sel", pattern_sel, e.pat);
        check_val("tick_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step_clk(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_clk(2);
    rst_n = 1'b1;
    m_state = M_RUN; m_scroll = '0; m_pat = '0; m_cnt = 0;
    sb.delete();
    step_clk(1);
    check_val("rst_scroll", scroll_x, 0);
    check_val("rst_pattern", pattern_sel, 0);
    check_val("rst_paused", paused, 0);
    check_val("rst_tick", frame_tick, 0);
  endtask

  // Model of one frame_start edge, committed at the next posedge.
  task automatic model_frame();
    logic       adv;
    logic [2:0] amt;
    exp_t       e;
    adv = (m_state != M_PAUSE);
    amt = (m_state == M_STEP && speed == 3'd0) ? 3'd1 : speed;
    if (adv) begin
      m_scroll = dir ? (m_scroll - {7'd0, amt}) : (m_scroll + {7'd0, amt});
      if (auto_cycle) begin
        if (m_cnt == HOLD - 1) begin
          m_cnt = 0;
          m_pat = m_pat + 2'd1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    if (!auto_cycle) m_cnt = 0;
    if (m_state == M_STEP) m_state = M_PAUSE;
    e.scroll = m_scroll; e.pat = m_pat; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic frame();
    vsync = 1'b0;
    model_frame();
    step_clk(3);
    vsync = 1'b1;
    step_clk(3);
  endtask

  task automatic press(input logic p, input logic s);
    pause_btn = p;
    step_btn  = s;
    step_clk(4);
    pause_btn = 1'b0;
    step_btn  = 1'b0;
    step_clk(3);
    if (p) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
    else if (s && m_state == M_PAUSE) m_state = M_STEP;
    check_val("paused_after_press", paused, (m_state != M_RUN));
  endtask

  initial begin
    step_clk(2);

    // 1: RUN, speed 3, five frames
    do_reset();
    speed = 3'd3; dir = 1'b0;
    repeat (5) frame();
    check_val("t1_scroll", scroll_x, 15);

    // 2: wrap both ways
    do_reset();
    dir = 1'b1; speed = 3'd4; frame();
    check_val("t2_1020", scroll_x, 1020);
    dir = 1'b0; speed = 3'd7; frame();
    check_val("t2_up_wrap", scroll_x, 3);
    dir = 1'b1; speed = 3'd1; frame();
    speed = 3'd5; frame();
    check_val("t2_down_wrap", scroll_x, 1021);

    // 3: pause latency, frozen frames, single step with speed 0
    dir = 1'b0; speed = 3'd2;
    pause_btn = 1'b1;
    step_clk(2);
    check_val("t3_paused_early", paused, 0);
    step_clk(1);
    check_val("t3_paused_3clk", paused, 1);
    pause_btn = 1'b0;
    step_clk(3);
    m_state = M_PAUSE;
    repeat (4) frame();
    check_val("t3_frozen", scroll_x, 1021);
    speed = 3'd0;
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    frame();
    check_val("t3_step_plus1", scroll_x, 1022);
    check_val("t3_back_paused", paused, 1);
    frame();
    check_val("t3_single_only", scroll_x, 1022);

    // 4: pause and step together in PAUSE -> RUN, no step
    speed = 3'd2;
    press(1'b1, 1'b1);
    check_val("t4_run", paused, 0);
    frame();
    check_val("t4_adv", scroll_x, 0);

    // Pause edge on a frame_start cycle in RUN: frame still advances
    speed = 3'd3;
    pause_btn = 1'b1;
    step_clk(2);
    frame();
    m_state = M_PAUSE;
    pause_btn = 1'b0;
    step_clk(3);
    check_val("edge_frame_scroll", scroll_x, 3);
    check_val("edge_frame_paused", paused, 1);
    frame();

    // 5: auto-cycle with HOLD_FRAMES=3
    do_reset();
    speed = 3'd1; dir = 1'b0; auto_cycle = 1'b1;
    for (int i = 0; i < 12; i++) frame();
    check_val("t5_pat_wrap", pattern_sel, 0);
    repeat (2) frame();
    auto_cycle = 1'b0; m_cnt = 0;
    step_clk(2);
    frame();
    auto_cycle = 1'b1;
    repeat (2) frame();
    check_val("t5_cnt_cleared", pattern_sel, 0);
    frame();
    check_val("t5_pat_next", pattern_sel, 1);

    // 6: pause held through reset, then reset during STEP
    auto_cycle = 1'b0;
    pause_btn = 1'b1;
    do_reset();
    step_clk(6);
    check_val("t6_held_no_toggle", paused, 0);
    pause_btn = 1'b0;
    step_clk(3);
    speed = 3'd4;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check_val("t6_in_step", paused, 1);
    do_reset();
    frame();
    check_val("t6_run_after_rst", scroll_x, 4);
    check_val("t6_not_paused", paused, 0);

    step_clk(4);
    check_val("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
